// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - four-pattern LED animator with its own step timebase
// Mode advances on a button rising edge or on an optional auto-advance step count.
module led_pattern_sequencer #(
  parameter int N_LEDS         = 6,
  parameter int TICK_DIV       = 12_500_000,
  parameter int AUTO_STEPS     = 0,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_next,
  input  logic              pause,
  output logic [N_LEDS-1:0] led,
  output logic [1:0]        mode,
  output logic              tick
);

  localparam int CW        = $clog2(TICK_DIV);
  localparam int SW        = (AUTO_STEPS == 0) ? 1 : $clog2(AUTO_STEPS + 1);
  localparam int PW        = $clog2(N_LEDS);
  localparam int AUTO_LAST = (AUTO_STEPS == 0) ? 0 : AUTO_STEPS - 1;

  typedef enum logic [1:0] {BLINK, SHIFT, COUNT, BREATHE} mode_t;

  mode_t             mode_q, mode_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [SW-1:0]     step_cnt, step_cnt_nxt;
  logic              blink, blink_nxt;
  logic [PW-1:0]     pos, pos_nxt;
  logic              shift_down, shift_down_nxt;
  logic [N_LEDS-1:0] count, count_nxt;
  logic [3:0]        duty, duty_nxt;
  logic              duty_down, duty_down_nxt;
  logic [3:0]        pwm, pwm_nxt;
  logic              btn_q;
  logic              tick_ev, adv_btn, adv_auto, adv;
  logic [N_LEDS-1:0] pat;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= BLINK;
      cnt        <= '0;
      step_cnt   <= '0;
      blink      <= 1'b0;
      pos        <= '0;
      shift_down <= 1'b0;
      count      <= '0;
      duty       <= '0;
      duty_down  <= 1'b0;
      pwm        <= '0;
      btn_q      <= 1'b0;
      tick       <= 1'b0;
      led        <= LED_ACTIVE_LOW ? '1 : '0;
    end else begin
      mode_q     <= mode_nxt;
      cnt        <= cnt_nxt;
      step_cnt   <= step_cnt_nxt;
      blink      <= blink_nxt;
      pos        <= pos_nxt;
      shift_down <= shift_down_nxt;
      count      <= count_nxt;
      duty       <= duty_nxt;
      duty_down  <= duty_down_nxt;
      pwm        <= pwm_nxt;
      btn_q      <= btn_next;
      tick       <= tick_ev;
      led        <= LED_ACTIVE_LOW ? ~pat : pat;
    end
  end

  always_comb begin
    mode_nxt       = mode_q;
    cnt_nxt        = cnt;
    step_cnt_nxt   = step_cnt;
    blink_nxt      = blink;
    pos_nxt        = pos;
    shift_down_nxt = shift_down;
    count_nxt      = count;
    duty_nxt       = duty;
    duty_down_nxt  = duty_down;
    pwm_nxt        = pwm;

    tick_ev  = !pause && (cnt == CW'(TICK_DIV - 1));
    adv_btn  = btn_next & ~btn_q;
    adv_auto = (AUTO_STEPS != 0) && tick_ev && (step_cnt == SW'(AUTO_LAST));
    adv      = adv_btn | adv_auto;

    if (adv) begin
      // A tick landing on an advance is swallowed: the new mode starts from entry state.
      mode_nxt       = mode_t'(mode_q + 2'd1);
      cnt_nxt        = '0;
      step_cnt_nxt   = '0;
      blink_nxt      = 1'b0;
      pos_nxt        = '0;
      shift_down_nxt = 1'b0;
      count_nxt      = '0;
      duty_nxt       = '0;
      duty_down_nxt  = 1'b0;
      pwm_nxt        = '0;
    end else if (!pause) begin
      pwm_nxt = pwm + 4'd1;
      if (tick_ev) begin
        cnt_nxt = '0;
        if (AUTO_STEPS != 0) step_cnt_nxt = step_cnt + SW'(1);
        case (mode_q)
          BLINK: blink_nxt = ~blink;
          SHIFT: begin
            // Direction flips as the end LED is reached so it is shown for a single step.
            if (!shift_down) begin
              pos_nxt = pos + PW'(1);
              if (pos == PW'(N_LEDS - 2)) shift_down_nxt = 1'b1;
            end else begin
              pos_nxt = pos - PW'(1);
              if (pos == PW'(1)) shift_down_nxt = 1'b0;
            end
          end
          COUNT: count_nxt = count + N_LEDS'(1);
          BREATHE: begin
            if (!duty_down) begin
              duty_nxt = duty + 4'd1;
              if (duty == 4'd14) duty_down_nxt = 1'b1;
            end else begin
              duty_nxt = duty - 4'd1;
              if (duty == 4'd1) duty_down_nxt = 1'b0;
            end
          end
          default: ;
        endcase
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_comb begin
    pat = '0;
    case (mode_q)
      BLINK:   pat = {N_LEDS{blink}};
      SHIFT:   pat = {{(N_LEDS-1){1'b0}}, 1'b1} << pos;
      COUNT:   pat = count;
      BREATHE: pat = {N_LEDS{pwm < duty}};
      default: pat = '0;
    endcase
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - random and directed bench against a tick-count reference model
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       pause = 1'b0;
  logic [5:0] led0, led1;
  logic [1:0] mode0, mode1;
  logic       tick0, tick1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_pattern_sequencer #(.N_LEDS(6), .TICK_DIV(4), .AUTO_STEPS(0), .LED_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .btn_next(btn), .pause(pause),
    .led(led0), .mode(mode0), .tick(tick0)
  );

  led_pattern_sequencer #(.N_LEDS(6), .TICK_DIV(4), .AUTO_STEPS(3), .LED_ACTIVE_LOW(1)) dut_auto (
    .clk(clk), .rst(rst), .btn_next(btn), .pause(pause),
    .led(led1), .mode(mode1), .tick(tick1)
  );

  // Reference state: pattern is derived from the number of ticks spent in the mode.
  int         auto_steps [2] = '{0, 3};
  int         m_mode [2];
  int         m_cnt  [2];
  int         m_k    [2];
  int         m_pwm  [2];
  bit         m_btnq [2];
  logic [5:0] e_led  [2];
  bit         e_tick [2];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] pattern(input int md, input int k, input int pwm);
    int t;
    int p;
    logic [5:0] one;
    one = 6'b000001;
    case (md)
      0: pattern = (k % 2 == 1) ? 6'h3f : 6'h00;
      1: begin
        t = k % 10;
        p = (t <= 5) ? t : 10 - t;
        pattern = one << p;
      end
      2: pattern = 6'(k % 64);
      default: begin
        t = k % 30;
        p = (t <= 15) ? t : 30 - t;
        pattern = (pwm < p) ? 6'h3f : 6'h00;
      end
    endcase
  endfunction

  task automatic model_update();
    bit tev;
    bit adv;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_mode[i] = 0; m_cnt[i] = 0; m_k[i] = 0; m_pwm[i] = 0; m_btnq[i] = 0;
        e_led[i] = 6'h3f; e_tick[i] = 0;
      end else begin
        tev = !pause && (m_cnt[i] == 3);
        adv = (btn && !m_btnq[i]) ||
              (auto_steps[i] != 0 && tev && (m_k[i] + 1 == auto_steps[i]));
        e_led[i]  = ~pattern(m_mode[i], m_k[i], m_pwm[i]);
        e_tick[i] = tev;
        if (adv) begin
          m_mode[i] = (m_mode[i] + 1) % 4;
          m_cnt[i] = 0; m_k[i] = 0; m_pwm[i] = 0;
        end else if (!pause) begin
          m_cnt[i] = (m_cnt[i] + 1) % 4;
          m_pwm[i] = (m_pwm[i] + 1) % 16;
          if (tev) m_k[i]++;
        end
        m_btnq[i] = btn;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("led0", int'(led0), int'(e_led[0]));
    check("tick0", int'(tick0), int'(e_tick[0]));
    check("mode0", int'(mode0), m_mode[0]);
    check("led1", int'(led1), int'(e_led[1]));
    check("tick1", int'(tick1), int'(e_tick[1]));
    check("mode1", int'(mode1), m_mode[1]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press();
    btn = 1'b1;
    cyc();
    btn = 1'b0;
    cyc();
  endtask

  initial begin
    int n;
    int start_mode;
    logic [5:0] held_led;
    bit found;

    // Reset and first tick latency
    rst = 1'b1;
    run(2);
    check("reset_led", int'(led0), 63);
    check("reset_mode", int'(mode0), 0);
    check("reset_tick", int'(tick0), 0);
    rst = 1'b0;
    n = 0;
    found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      cyc();
      if (tick0) begin
        n = i;
        found = 1;
      end
    end
    check("first_tick_cycles", n, 4);
    cyc();
    check("blink_first_on", int'(led0), 0);

    // SHIFT bounce and COUNT wrap
    press();
    check("mode_shift", int'(mode0), 1);
    run(12 * 4 + 4);
    press();
    check("mode_count", int'(mode0), 2);
    run(64 * 4 + 8);

    // Pause mid-COUNT
    run(2);
    pause = 1'b1;
    cyc();
    held_led = led0;
    run(19);
    check("pause_led_held", int'(led0), int'(held_led));
    pause = 1'b0;
    run(8);

    // Held button gives a single step
    start_mode = int'(mode0);
    btn = 1'b1;
    run(10);
    btn = 1'b0;
    cyc();
    check("held_btn_one_step", int'(mode0), (start_mode + 1) % 4);

    // Button edge on the cycle of the third tick in the auto instance
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_cnt[1] == 3 && m_k[1] == 2) begin
        found = 1;
        btn = 1'b1;
        cyc();
        btn = 1'b0;
      end else begin
        cyc();
      end
    end
    check("race_found", int'(found), 1);
    check("race_auto_mode", int'(mode1), 1);
    check("race_btn_mode", int'(mode0), 1);
    run(4);

    // Reach BREATHE, run past full duty, wrap to BLINK, reset mid-BREATHE
    press();
    press();
    check("mode_breathe", int'(mode0), 3);
    run(31 * 4);
    press();
    check("wrap_mode", int'(mode0), 0);
    check("wrap_entry_led", int'(led0), 63);
    press(); press(); press();
    run(20);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_breathe_mode", int'(mode0), 0);
    check("rst_breathe_led", int'(led0), 63);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      btn   = ($urandom_range(0, 11) == 0);
      pause = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst = 1'b0; btn = 1'b0; pause = 1'b0;
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
